// File: rtl/conv_pkg.sv
// Shared definitions for the convolution stream framer: tap count, default widths
// and the framer FSM state encoding.
package conv_pkg;

    localparam int KERNEL_TAPS        = 9;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_USER_WIDTH = 1;
    localparam int DEFAULT_WIN_WIDTH  = 16;

    localparam logic [3:0] LAST_TAP = 4'(KERNEL_TAPS - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND_PARAM = 2'd1,
        SEND_DATA  = 2'd2,
        DONE       = 2'd3
    } state_t;

endpackage

// File: rtl/conv_kernel_regfile.sv
// Kernel coefficient store: 9 entries, one write port, all entries readable in parallel
// as a flat vector (entry i at bits [i*DATA_WIDTH +: DATA_WIDTH]).
module conv_kernel_regfile
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              we,
    input  logic [3:0]                        addr,
    input  logic [DATA_WIDTH-1:0]             wdata,
    output logic [KERNEL_TAPS*DATA_WIDTH-1:0] taps
);

    logic [DATA_WIDTH-1:0] regs [KERNEL_TAPS];

    // Addresses beyond the last tap are dropped rather than aliased onto a real entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KERNEL_TAPS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (addr <= LAST_TAP)) begin
            regs[addr] <= wdata;
        end
    end

    for (genvar g = 0; g < KERNEL_TAPS; g++) begin : g_taps
        assign taps[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

endmodule

// File: rtl/conv_stream_framer.sv
// Frames 9 kernel bytes followed by num_windows x 9 source bytes onto an AXI-Stream output.
// Optional macro CONV_FRAMER_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module conv_stream_framer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int USER_WIDTH = DEFAULT_USER_WIDTH,
    parameter int WIN_WIDTH  = DEFAULT_WIN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  k_we,
    input  logic [3:0]            k_addr,
    input  logic [DATA_WIDTH-1:0] k_wdata,
    input  logic                  start,
    input  logic [WIN_WIDTH-1:0]  num_windows,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser
`ifdef CONV_FRAMER_FRAME_CNT_EN
    ,
    output logic [15:0]           frame_count
`endif
);

    state_t                          state;
    state_t                          state_next;
    logic [3:0]                      byte_cnt;
    logic [WIN_WIDTH-1:0]            win_cnt;
    logic [WIN_WIDTH-1:0]            num_win_q;
    logic                            err_q;
    logic [KERNEL_TAPS*DATA_WIDTH-1:0] taps;
    logic [DATA_WIDTH-1:0]           kernel_byte;
    logic                            accept;
    logic                            last_tap;
    logic                            last_win;
    logic                            handshake;

    // The kernel is frozen for the whole frame by only enabling writes while idle.
    conv_kernel_regfile #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_kernel (
        .clk   (clk),
        .rst   (rst),
        .we    (k_we && (state == IDLE)),
        .addr  (k_addr),
        .wdata (k_wdata),
        .taps  (taps)
    );

    assign kernel_byte = taps[byte_cnt*DATA_WIDTH +: DATA_WIDTH];
    assign accept      = (state == IDLE) && start && (num_windows != '0);
    assign last_tap    = (byte_cnt == LAST_TAP);
    assign last_win    = (win_cnt == (num_win_q - WIN_WIDTH'(1)));
    assign handshake   = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Data phase is a pure combinational pass-through so the frame adds no bubbles.
    always_comb begin
        state_next    = state;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SEND_PARAM;
                end
            end
            SEND_PARAM: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = kernel_byte;
                if (m_axis_tready && last_tap) begin
                    state_next = SEND_DATA;
                end
            end
            SEND_DATA: begin
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                s_axis_tready = m_axis_tready;
                m_axis_tlast  = last_tap && last_win;
                if (s_axis_tvalid && m_axis_tready && last_tap && last_win) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt  <= '0;
            win_cnt   <= '0;
            num_win_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && start && (num_windows == '0);
            if (accept) begin
                num_win_q <= num_windows;
                byte_cnt  <= '0;
                win_cnt   <= '0;
            end else if (handshake) begin
                if (last_tap) begin
                    byte_cnt <= '0;
                    if (state == SEND_DATA) begin
                        win_cnt <= win_cnt + WIN_WIDTH'(1);
                    end
                end else begin
                    byte_cnt <= byte_cnt + 4'd1;
                end
            end
        end
    end

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign err          = err_q;
    assign m_axis_tuser = '0;

`ifdef CONV_FRAMER_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
        end else if (state == DONE) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_stream_framer.sv
// Directed self-checking bench for conv_stream_framer; inputs change and outputs are
// sampled around the falling clock edge. Honors CONV_FRAMER_FRAME_CNT_EN if defined.
module tb_conv_stream_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        k_we;
    logic [3:0]  k_addr;
    logic [7:0]  k_wdata;
    logic        start;
    logic [15:0] num_windows;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tuser;
`ifdef CONV_FRAMER_FRAME_CNT_EN
    logic [15:0] frame_count;
`endif

    int checkCount = 0;
    int passCount  = 0;

    logic [7:0] kernRef [9];
    logic [7:0] expQ [$];
    logic [7:0] srcQ [$];

    always #5 clk = ~clk;

    conv_stream_framer dut (
        .clk           (clk),
        .rst           (rst),
        .k_we          (k_we),
        .k_addr        (k_addr),
        .k_wdata       (k_wdata),
        .start         (start),
        .num_windows   (num_windows),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
`ifdef CONV_FRAMER_FRAME_CNT_EN
        ,
        .frame_count   (frame_count)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the start pulse spans exactly one rising edge.
    task automatic applyStimulus(input logic [15:0] nWin);
        start       = 1'b1;
        num_windows = nWin;
        @(negedge clk);
        start       = 1'b0;
        num_windows = 16'd0;
    endtask

    task automatic writeKernel(input logic [3:0] addr, input logic [7:0] data);
        k_we    = 1'b1;
        k_addr  = addr;
        k_wdata = data;
        @(negedge clk);
        k_we    = 1'b0;
        if (addr < 4'd9) kernRef[addr] = data;
    endtask

    task automatic buildFrame(input logic [7:0] srcBase, input int nWin);
        expQ.delete();
        srcQ.delete();
        for (int i = 0; i < 9; i++) expQ.push_back(kernRef[i]);
        for (int i = 0; i < nWin * 9; i++) begin
            srcQ.push_back(srcBase + 8'(i));
            expQ.push_back(srcBase + 8'(i));
        end
    endtask

    // Streams until nStop output bytes have been accepted; injectCyc >= 0 fires a
    // kernel write plus a stray start on that cycle, both of which must be ignored.
    task automatic runFrame(input int nStop, input int nTotal, input bit toggleReady, input int injectCyc);
        int         outIdx = 0;
        int         srcIdx = 0;
        int         cyc = 0;
        bit         prevStall = 1'b0;
        logic [7:0] holdData = 8'h00;
        logic       holdLast = 1'b0;
        while (outIdx < nStop && cyc < 400) begin
            s_axis_tvalid = (srcIdx < srcQ.size());
            s_axis_tdata  = s_axis_tvalid ? srcQ[srcIdx] : 8'h00;
            m_axis_tready = toggleReady ? (cyc % 2 == 1) : 1'b1;
            k_we          = (cyc == injectCyc);
            k_addr        = 4'd4;
            k_wdata       = 8'hFF;
            start         = (cyc == injectCyc);
            num_windows   = (cyc == injectCyc) ? 16'd5 : 16'd0;
            #1;
            if (cyc == 0) checkOutput("first_valid", 32'(m_axis_tvalid), 32'd1);
            if (prevStall) begin
                checkOutput("hold_data", 32'(m_axis_tdata), 32'(holdData));
                checkOutput("hold_last", 32'(m_axis_tlast), 32'(holdLast));
            end
            if (outIdx < 9) checkOutput("src_ready_param", 32'(s_axis_tready), 32'd0);
            if (injectCyc >= 0 && cyc == injectCyc + 1) checkOutput("err_busy", 32'(err), 32'd0);
            if (m_axis_tvalid && m_axis_tready) begin
                checkOutput($sformatf("data[%0d]", outIdx), 32'(m_axis_tdata), 32'(expQ[outIdx]));
                checkOutput($sformatf("last[%0d]", outIdx), 32'(m_axis_tlast), 32'(outIdx == nTotal - 1));
                outIdx++;
            end
            if (s_axis_tvalid && s_axis_tready) srcIdx++;
            prevStall = m_axis_tvalid && !m_axis_tready;
            holdData  = m_axis_tdata;
            holdLast  = m_axis_tlast;
            cyc++;
            @(negedge clk);
        end
        k_we          = 1'b0;
        start         = 1'b0;
        num_windows   = 16'd0;
        s_axis_tvalid = 1'b0;
        checkOutput("frame_len", 32'(outIdx), 32'(nStop));
    endtask

    task automatic finishFrame();
        #1;
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("tvalid_in_done", 32'(m_axis_tvalid), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("done_cleared", 32'(done), 32'd0);
        checkOutput("busy_cleared", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        k_we          = 1'b0;
        k_addr        = 4'd0;
        k_wdata       = 8'h00;
        start         = 1'b0;
        num_windows   = 16'd0;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 9; i++) kernRef[i] = 8'h00;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("rst_tlast", 32'(m_axis_tlast), 32'd0);
        checkOutput("rst_s_tready", 32'(s_axis_tready), 32'd0);
        checkOutput("rst_tuser", 32'(m_axis_tuser), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single window, kernel 1..9, data 10..18");
        for (int i = 0; i < 9; i++) writeKernel(4'(i), 8'(i + 1));
        writeKernel(4'd12, 8'h55);
        buildFrame(8'd10, 1);
        applyStimulus(16'd1);
        #1;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        checkOutput("first_byte_k0", 32'(m_axis_tdata), 32'd1);
        @(negedge clk);
        runFrame(18, 18, 1'b0, -1);
        finishFrame();

        $display("[TB] three windows, toggling tready, ignored write and start mid-frame");
        buildFrame(8'h20, 3);
        applyStimulus(16'd3);
        runFrame(36, 36, 1'b1, 20);
        finishFrame();

        $display("[TB] kernel entry 4 must still hold its pre-frame value");
        buildFrame(8'h40, 1);
        applyStimulus(16'd1);
        runFrame(18, 18, 1'b0, -1);
        finishFrame();

        $display("[TB] zero-window start");
        applyStimulus(16'd0);
        #1;
        checkOutput("err_pulse", 32'(err), 32'd1);
        checkOutput("err_busy_low", 32'(busy), 32'd0);
        checkOutput("err_tvalid_low", 32'(m_axis_tvalid), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("err_cleared", 32'(err), 32'd0);
        checkOutput("err_still_idle", 32'(busy), 32'd0);
        @(negedge clk);

        $display("[TB] reset after five data bytes");
        buildFrame(8'h60, 3);
        applyStimulus(16'd3);
        runFrame(14, 36, 1'b0, -1);
        rst           = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h99;
        m_axis_tready = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("midrst_tlast", 32'(m_axis_tlast), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_s_tready", 32'(s_axis_tready), 32'd0);
        rst           = 1'b0;
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 9; i++) kernRef[i] = 8'h00;
        @(negedge clk);
        writeKernel(4'd0, 8'h77);
        buildFrame(8'h80, 1);
        applyStimulus(16'd1);
        runFrame(18, 18, 1'b0, -1);
        finishFrame();

`ifdef CONV_FRAMER_FRAME_CNT_EN
        $display("[TB] second frame after reset for the frame counter");
        buildFrame(8'hA0, 1);
        applyStimulus(16'd1);
        runFrame(18, 18, 1'b0, -1);
        finishFrame();
        #1;
        checkOutput("frame_count", 32'(frame_count), 32'd2);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/conv_stream_framer.md
CONV_STREAM_FRAMER -- requirements
Module: conv_stream_framer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte width of kernel coefficients and stream data.
REQ-002 Parameter USER_WIDTH, default 1, tuser width.
REQ-003 Parameter WIN_WIDTH, default 16, width of the window-count field.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 k_we / k_addr / k_wdata  in  1 / 4 / DATA_WIDTH  kernel coefficient write port, 9 entries.
REQ-007 start / num_windows  in  1 / WIN_WIDTH  frame start pulse and number of 9-byte windows.
REQ-008 busy / done / err  out  1 / 1 / 1  frame in progress; 1-cycle completion pulse; 1-cycle rejected-start pulse.
REQ-009 s_axis_tdata / s_axis_tvalid / s_axis_tready  in / in / out  DATA_WIDTH / 1 / 1  window-byte source stream.
REQ-010 m_axis_tdata / tvalid / tready / tlast / tuser  out / out / in / out / out  DATA_WIDTH / 1 / 1 / 1 / USER_WIDTH  framed output to the convolution accelerator.

Function
REQ-011 Frame format: 9 kernel bytes (index 0..8), then num_windows x 9 data bytes; tlast only on the final data byte.
REQ-012 FSM states: IDLE, SEND_PARAM, SEND_DATA, DONE.
REQ-013 IDLE -> SEND_PARAM on start with num_windows != 0; latch num_windows; busy=1 from the next cycle.
REQ-014 start with num_windows == 0 in IDLE: no frame; err=1 for one cycle; remain IDLE.
REQ-015 start while busy: ignored, no err.
REQ-016 SEND_PARAM: m_axis_tvalid=1, m_axis_tdata=kernel[byte_cnt]; byte_cnt advances only on tvalid&&tready.
REQ-017 SEND_PARAM -> SEND_DATA on the handshake of kernel byte 8; byte_cnt wraps to 0.
REQ-018 SEND_DATA: combinational pass-through; m_axis_tvalid=s_axis_tvalid, m_axis_tdata=s_axis_tdata, s_axis_tready=m_axis_tready.
REQ-019 s_axis_tready=0 in every state other than SEND_DATA.
REQ-020 byte_cnt 0..8 wraps on each handshake of byte 8; win_cnt increments on that wrap.
REQ-021 m_axis_tlast=1 when state is SEND_DATA, byte_cnt==8 and win_cnt==num_windows-1.
REQ-022 The handshake of the tlast byte moves SEND_DATA -> DONE; DONE asserts done for one cycle, then goes to IDLE with busy=0.
REQ-023 While tvalid=1 and tready=0, tdata and tlast stay stable (AXI-Stream hold rule).
REQ-024 Kernel writes are applied in IDLE only.
REQ-025 Kernel writes while busy are ignored, so the kernel is constant for the whole frame.
REQ-026 Kernel writes with k_addr > 8 are ignored.
REQ-027 m_axis_tuser = 0 always.
REQ-028 The frame has no added latency: the first kernel byte is valid in the cycle after start is accepted.

Reset
REQ-029 rst clears to: state IDLE, byte_cnt/win_cnt 0, all kernel entries 0.
REQ-030 rst clears to: busy/done/err 0, m_axis_tvalid 0, m_axis_tlast 0, s_axis_tready 0.
REQ-031 rst mid-frame abandons the frame without emitting tlast; outputs hold the reset values from the next cycle.

Configuration
REQ-032 With macro CONV_FRAMER_FRAME_CNT_EN defined, add output frame_count [15:0].
REQ-033 frame_count resets to 0, increments on each done pulse and wraps at 65535->0.
REQ-034 Without CONV_FRAMER_FRAME_CNT_EN the port and counter are absent; all other behaviour is identical.

Structure
REQ-035 Shared package conv_pkg holds: KERNEL_TAPS=9, the FSM state encoding typedef, and the default widths.
REQ-036 One sub-module conv_kernel_regfile (9 x DATA_WIDTH, single write port, 9 parallel reads) holds the kernel; the FSM and counters stay in the top module.

Verification
REQ-037 Kernel writes 1..9, start with num_windows=1, tready=1, source bytes 10..18 -> output 1..9,10..18; tlast only on 18; done 1 cycle after.
REQ-038 num_windows=3 with tready toggling every cycle -> 36 bytes in order, stalls hold data stable, tlast on byte 36 only.
REQ-039 start with num_windows=0 -> err pulse; no tvalid; busy stays 0.
REQ-040 Kernel write addr 4 = 0xFF during SEND_DATA -> ignored; next frame still sends the old value.
REQ-041 rst asserted after 5 data bytes -> tvalid=0 next cycle; new frame after release starts again from kernel byte 0.
REQ-042 With CONV_FRAMER_FRAME_CNT_EN, 2 back-to-back frames -> frame_count reads 2.
